// File: rtl/vpu_bram_pkg.sv
// Shared types and constants for the VPU dual-port block RAM.
package vpu_bram_pkg;

    typedef enum logic [1:0] {
        RDW_READ_FIRST,
        RDW_WRITE_FIRST,
        RDW_NO_CHANGE
    } rdw_mode_e;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/bram_rd_pipe.sv
// Per-port read return path: 1 or 2 register stages, read-valid strobe, NO_CHANGE hold.
module bram_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_fire,
    input  logic              i_hold,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid
);

    logic              w_fire;
    logic              w_out_fire;
    logic [DATA_W-1:0] w_out_data;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    assign w_fire = i_fire & ~i_hold;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_s1_vld;
            logic [DATA_W-1:0] r_s1_data;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_s1_vld  <= 1'b0;
                    r_s1_data <= '0;
                end else begin
                    r_s1_vld <= w_fire;
                    if (w_fire) r_s1_data <= i_data;
                end
            end

            assign w_out_fire = r_s1_vld;
            assign w_out_data = r_s1_data;
        end else begin : g_lat1
            assign w_out_fire = w_fire;
            assign w_out_data = i_data;
        end
    endgenerate

    // rdata only moves on a valid return, so it holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_out_fire;
            if (w_out_fire) r_rdata <= w_out_data;
        end
    end

    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;

endmodule

// File: rtl/bram_tdp_be.sv
// True dual-port RAM with byte enables, configurable read latency and
// deterministic write-write collision handling (port A wins overlapping lanes).
module bram_tdp_be
    import vpu_bram_pkg::*;
#(
    parameter int        ADDR_W     = 8,
    parameter int        DEPTH      = 2**ADDR_W,
    parameter int        DATA_W     = 32,
    parameter int        RD_LAT     = 1,
    parameter rdw_mode_e RDW_MODE_A = RDW_READ_FIRST,
    parameter rdw_mode_e RDW_MODE_B = RDW_READ_FIRST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_en,
    input  logic [DATA_W/BYTE_W-1:0] a_we,
    input  logic [ADDR_W-1:0]        a_addr,
    input  logic [DATA_W-1:0]        a_wdata,
    output logic [DATA_W-1:0]        a_rdata,
    output logic                     a_rvalid,
    input  logic                     b_en,
    input  logic [DATA_W/BYTE_W-1:0] b_we,
    input  logic [ADDR_W-1:0]        b_addr,
    input  logic [DATA_W-1:0]        b_wdata,
    output logic [DATA_W-1:0]        b_rdata,
    output logic                     b_rvalid,
    output logic                     wr_collision
);

    localparam int              NB        = DATA_W / BYTE_W;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
            $error("bram_tdp_be: RD_LAT must be 1 or 2");
        end
        if (DATA_W % BYTE_W != 0) begin : g_bad_width
            $error("bram_tdp_be: DATA_W must be a multiple of 8");
        end
        if (DEPTH > 2**ADDR_W || DEPTH < 1) begin : g_bad_depth
            $error("bram_tdp_be: DEPTH must be in 1..2**ADDR_W");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_a_inr;
    logic              w_b_inr;
    logic              w_same_addr;
    logic              w_coll;
    logic [NB-1:0]     w_a_lane_wr;
    logic [NB-1:0]     w_b_lane_wr;
    logic [DATA_W-1:0] w_a_old;
    logic [DATA_W-1:0] w_b_old;
    logic [DATA_W-1:0] w_a_merge;
    logic [DATA_W-1:0] w_b_merge;
    logic [DATA_W-1:0] w_a_rd_word;
    logic [DATA_W-1:0] w_b_rd_word;
    logic              w_a_hold;
    logic              w_b_hold;
    logic              r_coll;

    assign w_a_inr     = ({1'b0, a_addr} < DEPTH_LIM);
    assign w_b_inr     = ({1'b0, b_addr} < DEPTH_LIM);
    assign w_same_addr = a_en & b_en & (a_addr == b_addr);
    assign w_coll      = w_same_addr & (|(a_we & b_we));

    // Out-of-range reads see zero; the array read is always the pre-write word.
    assign w_a_old = w_a_inr ? r_mem[a_addr] : '0;
    assign w_b_old = w_b_inr ? r_mem[b_addr] : '0;

    always_comb begin
        w_a_lane_wr = '0;
        w_b_lane_wr = '0;
        w_a_merge   = w_a_old;
        w_b_merge   = w_b_old;
        for (int i = 0; i < NB; i++) begin
            w_a_lane_wr[i] = a_en & a_we[i] & w_a_inr;
            w_b_lane_wr[i] = b_en & b_we[i] & w_b_inr & ~(w_same_addr & w_a_lane_wr[i]);
            if (a_we[i] && w_a_inr) w_a_merge[i*BYTE_W +: BYTE_W] = a_wdata[i*BYTE_W +: BYTE_W];
            if (b_we[i] && w_b_inr) w_b_merge[i*BYTE_W +: BYTE_W] = b_wdata[i*BYTE_W +: BYTE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NB; i++) begin
                if (w_a_lane_wr[i]) r_mem[a_addr][i*BYTE_W +: BYTE_W] <= a_wdata[i*BYTE_W +: BYTE_W];
                if (w_b_lane_wr[i]) r_mem[b_addr][i*BYTE_W +: BYTE_W] <= b_wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_coll <= 1'b0;
        else        r_coll <= w_coll;
    end

    assign wr_collision = r_coll;

    assign w_a_rd_word = (RDW_MODE_A == RDW_WRITE_FIRST) ? w_a_merge : w_a_old;
    assign w_b_rd_word = (RDW_MODE_B == RDW_WRITE_FIRST) ? w_b_merge : w_b_old;
    assign w_a_hold    = (RDW_MODE_A == RDW_NO_CHANGE) & (|a_we);
    assign w_b_hold    = (RDW_MODE_B == RDW_NO_CHANGE) & (|b_we);

    bram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_fire   (a_en),
        .i_hold   (w_a_hold),
        .i_data   (w_a_rd_word),
        .o_rdata  (a_rdata),
        .o_rvalid (a_rvalid)
    );

    bram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_fire   (b_en),
        .i_hold   (w_b_hold),
        .i_data   (w_b_rd_word),
        .o_rdata  (b_rdata),
        .o_rvalid (b_rvalid)
    );

endmodule

// File: doc/bram_tdp_be.md
Name: bram_tdp_be

Overview:
- Single-clock true dual-port block RAM for the VPU: tile, palette and sprite-attribute storage shared between the CPU-side bus and the video fetch pipeline.
- Each port has per-byte write enables and a selectable read-during-write mode.
- Read latency is configurable at 1 or 2 cycles, and each port has a read-valid strobe.
- Writes from both ports to the same address and byte in one cycle resolve deterministically and are flagged.

Parameters:
- ADDR_W, 8, address width.
- DEPTH, 2**ADDR_W, number of words; may be a non-power-of-two value ≤ 2**ADDR_W.
- DATA_W, 32, word width; must be a multiple of 8.
- NB, DATA_W/8, number of byte lanes; derived, not overridable.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2; other values are an elaboration error.
- RDW_MODE_A, RDW_READ_FIRST, port A read-during-write mode (rdw_mode_e).
- RDW_MODE_B, RDW_READ_FIRST, port B read-during-write mode.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- a_en  in  1  port A access request.
- a_we  in  NB  port A byte write enables.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_rdata  out  DATA_W  port A read data.
- a_rvalid  out  1  a_rdata updated this cycle.
- b_en, b_we, b_addr, b_wdata, b_rdata, b_rvalid: same as port A, for port B.
- wr_collision  out  1  one-cycle pulse: both ports wrote an overlapping byte of the same address.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - a_rdata, b_rdata, a_rvalid, b_rvalid and wr_collision go to 0; all pipeline stages are cleared.
  - RAM contents are not modified; en/we are ignored during reset.
  - Reads in flight when reset asserts are dropped and never produce rvalid.
- Access:
  - A port accesses the RAM on any cycle with en=1.
  - Byte lane i is written when we[i]=1; other lanes keep their contents.
- Latency and valid:
  - The read for the access in cycle T appears on rdata with rvalid=1 at cycle T+RD_LAT.
  - When RD_LAT=2, the extra stage is a plain register; a new access may be issued every cycle.
  - rdata holds its last value when rvalid=0.
- Same-port read-during-write (per port mode):
  - RDW_READ_FIRST: rdata returns the word as it was before the write.
  - RDW_WRITE_FIRST: rdata returns the merged new word; unwritten lanes show old data.
  - RDW_NO_CHANGE: a cycle with any we bit set produces no rvalid and leaves rdata unchanged; a cycle with we=0 reads normally.
- Cross-port, same cycle, same address:
  - A read on one port while the other port writes returns the pre-write word, regardless of mode.
- Write-write collision:
  - Condition: both en=1, a_addr==b_addr, and (a_we & b_we)≠0.
  - Overlapping lanes take port A data; non-overlapping lanes take the data of whichever port enabled them.
  - wr_collision=1 in cycle T+1; it is not asserted when the lanes are disjoint.
- Out-of-range addresses (addr ≥ DEPTH):
  - Writes are dropped.
  - Reads return all-zero data, with rvalid still asserted normally.
- Same-port sequence: a read in T+1 of an address written in T returns the new data.
- Only the RAM array uses no reset; all control and output registers are reset.

Decomposition:
- Package vpu_bram_pkg holds:
  - typedef enum rdw_mode_e {RDW_READ_FIRST, RDW_WRITE_FIRST, RDW_NO_CHANGE};
  - localparam BYTE_W=8.
- Natural sub-module: bram_rd_pipe, instantiated once per port.
  - It takes the raw read word plus a "fire" flag.
  - It applies the 1- or 2-stage register and generates rvalid.
  - It handles the NO_CHANGE hold.
- The top level owns the array, byte-lane merge, collision arbitration and range checks.

Test Plan:
- Reset and valid timing: DATA_W=32, RD_LAT=2.
  - Assert rst_n=0 with a_en=1, a_we=4'hF, a_addr=0x10.
  - Then read 0x10 on port A with rst_n=1.
  - Required: no write happened (RAM initialised to 0 → read returns 0); a_rvalid rises exactly 2 cycles after the read; all outputs 0 during reset.
- Byte enables: word 0x20 holds 0x11223344; A writes a_we=4'b0101, a_wdata=0xAABBCCDD; then A reads 0x20.
  - Required: 0x11BB33DD after RD_LAT cycles.
- Read-during-write modes: word 0x05 holds 0xCAFEF00D; write 0xDEADBEEF with we=4'hF and en=1.
  - READ_FIRST → rdata=0xCAFEF00D, rvalid=1.
  - WRITE_FIRST → rdata=0xDEADBEEF, rvalid=1.
  - NO_CHANGE → rvalid=0 and rdata unchanged.
- Write collision on address 0x30: A writes we=4'b0011, data 0x0000AAAA; B writes we=4'b0110, data 0x00BBBB00; then read.
  - Required: wr_collision=1 the next cycle; the word reads 0x00BBAAAA (lane 1 taken from A).
  - Repeat with B we=4'b1100: wr_collision=0.
- Cross-port read: A writes 0x12345678 to 0x40 (old value 0x0); B reads 0x40 in the same cycle and again the next cycle.
  - Required: first b_rdata=0x00000000, second 0x12345678.
- Out-of-range access: DEPTH=200; write 0xFFFFFFFF to 210, then read 210 and address 210 mod 256's aliases.
  - Required: read of 210 returns 0 with rvalid=1; no other word changes (spot-check 10 and 199 unchanged).
